sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the two-bank SRAM array (bank0/bank1, 4 byte-lanes per bank, 13-bit word address) between two requesters.
- Port 0 is the AHB-side slave interface path; port 1 is a secondary master (DMA/BIST).
- Round-robin arbitration with optional lock for back-to-back bursts and a forced-rotation limit.
- Registers the winning command onto the SRAM pins and returns read data with a valid strobe to the owning port.

Parameters:
LOCK_MAX, 16, max consecutive granted beats to one locked port while the other port is requesting (range 1..255).
P0_FIRST, 1, port that wins the first arbitration after reset when both request (1 = port 0, 0 = port 1).

Ports:
hclk  in  1  clock
hrst_n  in  1  reset, asynchronous, active-low
p0_req  in  1  port 0 access request, held until granted
p0_lock  in  1  port 0 requests to keep ownership for the next beat
p0_we  in  1  1 = write, 0 = read
p0_addr  in  14  [13] bank select, [12:0] word address
p0_be  in  4  byte enables, active-high, bit i = byte lane i
p0_wdata  in  32  write data
p0_gnt  out  1  command accepted this cycle (combinational)
p0_rvalid  out  1  read data valid for port 0
p1_req, p1_lock, p1_we, p1_addr, p1_be, p1_wdata, p1_gnt, p1_rvalid  same as port 0 for port 1
rdata  out  32  read data, shared by both ports, qualified by pN_rvalid
sram_addr  out  13  SRAM word address
sram_wdata  out  32  SRAM write data
wen  out  1  0 = write, 1 = read
bank0_csn  out  4  bank0 lane chip selects, active-low
bank1_csn  out  4  bank1 lane chip selects, active-low
sram_d_0..sram_d_7  in  8 each  SRAM read bytes; 0-3 = bank0 lanes 0-3, 4-7 = bank1 lanes 0-3

Behaviour:
- Reset values:
  - sram_addr = 0, sram_wdata = 0, wen = 1, bank0_csn = bank1_csn = 4'hF.
  - p0_gnt = p1_gnt = 0, p0_rvalid = p1_rvalid = 0, rdata = 0.
  - FSM = IDLE, lock counter = 0, rr_last per P0_FIRST.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: no port owns the SRAM.
  - OWNn: port n was granted last cycle with pN_lock = 1.
- Arbitration in cycle N (combinational grant):
  - Only one port requests: that port wins.
  - Both request in IDLE: the port not granted most recently (rr_last) wins.
  - Both request in OWNn: port n wins unless lock_cnt == LOCK_MAX, in which case the other port wins.
  - At most one pN_gnt is high per cycle; grant requires pN_req = 1.
- State transitions on each grant:
  - Grant to n with pN_lock = 1 -> OWNn.
  - lock_cnt resets to 1 on an ownership change or first locked grant; otherwise it increments, saturating at LOCK_MAX.
  - Grant with pN_lock = 0 -> IDLE, lock_cnt = 0.
  - No grant -> IDLE, lock_cnt = 0.
  - rr_last updates on every grant.
- Command path:
  - The granted command appears on the SRAM pins in cycle N+1, registered.
  - bankX_csn = ~be for the addressed bank, 4'hF for the other bank.
  - wen = ~we; sram_wdata = granted wdata.
- No grant in cycle N: in N+1 both csn = 4'hF, wen = 1, sram_addr and sram_wdata hold their previous values.
- be = 0 on a grant: access consumes the slot, but both csn = 4'hF. A read still returns rvalid.
- Read return:
  - SRAM data is valid in cycle N+2.
  - rdata is registered from sram_d_0..3 or sram_d_4..7 per the captured bank.
  - pN_rvalid is asserted in cycle N+3 for exactly one cycle.
- Writes produce no rvalid.
- Throughput:
  - One access per cycle, pipelined.
  - Reads and writes may alternate every cycle; no turnaround bubble.
- Asynchronous reset mid-operation:
  - All pending reads are dropped; no rvalid after reset release.
  - csn goes to 4'hF immediately.

Test Plan:
- Single read: p0 read bank0 addr 13'h0005, be 4'hF. Required: p0_gnt same cycle; bank0_csn = 0 and sram_addr = 5 in N+1; with sram_d_3..0 = 44,33,22,11, p0_rvalid and rdata = 32'h44332211 in N+3.
- Byte write: p1 write addr 14'h2010 (bank1, word 0x10), be 4'b0100, wdata 32'hA5A5A5A5. Required: in N+1 bank1_csn = 4'b1011, bank0_csn = 4'hF, wen = 0, sram_addr = 13'h0010, sram_wdata = 32'hA5A5A5A5; no rvalid.
- Round-robin: both ports request continuously, lock = 0. Required: grants alternate p0 (P0_FIRST = 1), p1, p0, p1 over 4 cycles.
- Lock limit (LOCK_MAX = 4): p0 locked burst, p1 requesting throughout. Required: p0 granted 4 consecutive cycles, then p1 granted in the 5th cycle.
- Mixed pipeline: alternating p0 read / p1 write every cycle for 8 cycles. Required: every rvalid goes only to p0 with correct per-address data; wen toggles each cycle.
- Reset mid-read: assert hrst_n = 0 in cycle N+1 of a read. Required: csn = 4'hF immediately; no p0_rvalid afterwards; first grant after release goes to p0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a two-bank, 4-lane SRAM between two requesters.
// Ports: pN_req/lock/we/addr/be/wdata in, pN_gnt (comb) / pN_rvalid out, shared rdata;
//        registered SRAM pins sram_addr/sram_wdata/wen/bank0_csn/bank1_csn, read bytes sram_d_0..7.
// Grant is combinational in cycle N, SRAM pins in N+1, read data valid in N+3.
// A requester is backpressured simply by not receiving pN_gnt; it holds pN_req until granted.
module sram_port_arbiter #(
   parameter int unsigned LOCK_MAX = 16,
   parameter bit          P0_FIRST = 1'b1
) (
   input  logic        hclk,
   input  logic        hrst_n,
   input  logic        p0_req,
   input  logic        p0_lock,
   input  logic        p0_we,
   input  logic [13:0] p0_addr,
   input  logic [3:0]  p0_be,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   input  logic        p1_req,
   input  logic        p1_lock,
   input  logic        p1_we,
   input  logic [13:0] p1_addr,
   input  logic [3:0]  p1_be,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] rdata,
   output logic [12:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic        wen,
   output logic [3:0]  bank0_csn,
   output logic [3:0]  bank1_csn,
   input  logic [7:0]  sram_d_0,
   input  logic [7:0]  sram_d_1,
   input  logic [7:0]  sram_d_2,
   input  logic [7:0]  sram_d_3,
   input  logic [7:0]  sram_d_4,
   input  logic [7:0]  sram_d_5,
   input  logic [7:0]  sram_d_6,
   input  logic [7:0]  sram_d_7
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   state_t      state_q, state_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   // rr_last = 1 means port 1 was granted most recently, so port 0 wins the next tie in IDLE.
   logic        rr_last_q, rr_last_d;
   logic        gnt0, gnt1, any_gnt;
   logic [7:0]  lock_cnt_inc;

   logic        sel_we;
   logic [13:0] sel_addr;
   logic [3:0]  sel_be;
   logic [31:0] sel_wdata;

   // Read return pipeline: s1 = command on the pins, s2 = SRAM data on sram_d.
   logic        s1_rd, s1_port, s1_bank;
   logic        s2_rd, s2_port, s2_bank;

   assign lock_cnt_inc = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 8'd1;

   // Arbitration and next-state
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      state_d    = IDLE;
      lock_cnt_d = 8'd0;
      rr_last_d  = rr_last_q;

      if (p0_req && p1_req) begin
         case (state_q)
            OWN0:    if (lock_cnt_q == LOCK_MAX_C) gnt1 = 1'b1; else gnt0 = 1'b1;
            OWN1:    if (lock_cnt_q == LOCK_MAX_C) gnt0 = 1'b1; else gnt1 = 1'b1;
            default: if (rr_last_q) gnt0 = 1'b1; else gnt1 = 1'b1;
         endcase
      end else begin
         gnt0 = p0_req;
         gnt1 = p1_req;
      end

      if (gnt0) begin
         rr_last_d = 1'b0;
         if (p0_lock) begin
            state_d    = OWN0;
            lock_cnt_d = (state_q == OWN0) ? lock_cnt_inc : 8'd1;
         end
      end else if (gnt1) begin
         rr_last_d = 1'b1;
         if (p1_lock) begin
            state_d    = OWN1;
            lock_cnt_d = (state_q == OWN1) ? lock_cnt_inc : 8'd1;
         end
      end
   end

   assign any_gnt   = gnt0 | gnt1;
   assign p0_gnt    = gnt0 & hrst_n;
   assign p1_gnt    = gnt1 & hrst_n;

   assign sel_we    = gnt1 ? p1_we    : p0_we;
   assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
   assign sel_be    = gnt1 ? p1_be    : p0_be;
   assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_q    <= IDLE;
         lock_cnt_q <= 8'd0;
         rr_last_q  <= P0_FIRST;
         sram_addr  <= 13'd0;
         sram_wdata <= 32'd0;
         wen        <= 1'b1;
         bank0_csn  <= 4'hF;
         bank1_csn  <= 4'hF;
         s1_rd      <= 1'b0;
         s1_port    <= 1'b0;
         s1_bank    <= 1'b0;
         s2_rd      <= 1'b0;
         s2_port    <= 1'b0;
         s2_bank    <= 1'b0;
         p0_rvalid  <= 1'b0;
         p1_rvalid  <= 1'b0;
         rdata      <= 32'd0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         rr_last_q  <= rr_last_d;

         if (any_gnt) begin
            sram_addr  <= sel_addr[12:0];
            sram_wdata <= sel_wdata;
            wen        <= ~sel_we;
            bank0_csn  <= sel_addr[13] ? 4'hF : ~sel_be;
            bank1_csn  <= sel_addr[13] ? ~sel_be : 4'hF;
         end else begin
            // Address and write data hold; only the strobes go idle.
            wen        <= 1'b1;
            bank0_csn  <= 4'hF;
            bank1_csn  <= 4'hF;
         end

         // A be=0 read still occupies the slot and returns rvalid (data undefined).
         s1_rd   <= any_gnt & ~sel_we;
         s1_port <= gnt1;
         s1_bank <= sel_addr[13];
         s2_rd   <= s1_rd;
         s2_port <= s1_port;
         s2_bank <= s1_bank;

         p0_rvalid <= s2_rd & ~s2_port;
         p1_rvalid <= s2_rd & s2_port;
         if (s2_rd) begin
            rdata <= s2_bank ? {sram_d_7, sram_d_6, sram_d_5, sram_d_4}
                             : {sram_d_3, sram_d_2, sram_d_1, sram_d_0};
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized + directed bench for sram_port_arbiter with an SRAM model
// and a transaction-level reference model compared every cycle on the falling edge.
// Inputs are driven 1 time unit after the rising edge.
module tb_sram_port_arbiter;
   localparam int LOCK_MAX = 4;

   logic        hclk = 1'b0;
   logic        hrst_n = 1'b0;
   logic        p0_req = 1'b0, p0_lock = 1'b0, p0_we = 1'b0;
   logic [13:0] p0_addr = '0;
   logic [3:0]  p0_be = '0;
   logic [31:0] p0_wdata = '0;
   logic        p1_req = 1'b0, p1_lock = 1'b0, p1_we = 1'b0;
   logic [13:0] p1_addr = '0;
   logic [3:0]  p1_be = '0;
   logic [31:0] p1_wdata = '0;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, wen;
   logic [31:0] rdata, sram_wdata;
   logic [12:0] sram_addr;
   logic [3:0]  bank0_csn, bank1_csn;
   logic [7:0]  sd [8] = '{default: 8'h00};

   int n_chk = 0;
   int n_fail = 0;

   sram_port_arbiter #(.LOCK_MAX(LOCK_MAX), .P0_FIRST(1'b1)) dut (
      .hclk(hclk), .hrst_n(hrst_n),
      .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_be(p0_be), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_be(p1_be), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .rdata(rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .wen(wen),
      .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
      .sram_d_0(sd[0]), .sram_d_1(sd[1]), .sram_d_2(sd[2]), .sram_d_3(sd[3]),
      .sram_d_4(sd[4]), .sram_d_5(sd[5]), .sram_d_6(sd[6]), .sram_d_7(sd[7])
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- SRAM model (64 words per bank is enough for the stimulus) ----------------
   logic [31:0] sram_mem [2][64] = '{default: 32'h0};
   always @(posedge hclk) begin
      for (int l = 0; l < 4; l++) begin
         if (!bank0_csn[l]) begin
            if (!wen) sram_mem[0][sram_addr[5:0]][8*l +: 8] <= sram_wdata[8*l +: 8];
            else      sd[l] <= sram_mem[0][sram_addr[5:0]][8*l +: 8];
         end
         if (!bank1_csn[l]) begin
            if (!wen) sram_mem[1][sram_addr[5:0]][8*l +: 8] <= sram_wdata[8*l +: 8];
            else      sd[l+4] <= sram_mem[1][sram_addr[5:0]][8*l +: 8];
         end
      end
   end

   // ---------------- Reference model + compare ----------------
   typedef struct {
      int          due;
      int          port;
      bit          chk_data;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t     rdq[$];
   logic [31:0] mmem [2][64] = '{default: 32'h0};
   int          cyc = 0;
   int          m_owner = -1;   // port holding a lock, -1 when none
   int          m_run = 0;      // consecutive locked beats of m_owner
   int          m_last = 1;     // port granted most recently
   logic [12:0] e_addr = '0;
   logic [31:0] e_wdata = '0;
   logic        e_wen = 1'b1;
   logic [3:0]  e_csn0 = 4'hF, e_csn1 = 4'hF;

   always @(negedge hclk) begin : cmp
      int          w;
      logic        e_rv0, e_rv1, s_lock, s_we;
      logic [13:0] s_addr;
      logic [3:0]  s_be;
      logic [31:0] s_wd, e_rd;
      bit          e_chk;
      if (!hrst_n) begin
         rdq.delete();
         m_owner = -1; m_run = 0; m_last = 1;
         e_addr = '0; e_wdata = '0; e_wen = 1'b1; e_csn0 = 4'hF; e_csn1 = 4'hF;
         chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
         chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
         chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
         chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
         chk("rst_bank0_csn", 32'(bank0_csn), 32'hF);
         chk("rst_bank1_csn", 32'(bank1_csn), 32'hF);
         chk("rst_wen", 32'(wen), 32'd1);
         chk("rst_sram_addr", 32'(sram_addr), 32'd0);
         chk("rst_sram_wdata", sram_wdata, 32'd0);
         chk("rst_rdata", rdata, 32'd0);
      end else begin
         // Outputs produced by earlier grants
         chk("pin_sram_addr", 32'(sram_addr), 32'(e_addr));
         chk("pin_sram_wdata", sram_wdata, e_wdata);
         chk("pin_wen", 32'(wen), 32'(e_wen));
         chk("pin_bank0_csn", 32'(bank0_csn), 32'(e_csn0));
         chk("pin_bank1_csn", 32'(bank1_csn), 32'(e_csn1));
         e_rv0 = 1'b0; e_rv1 = 1'b0; e_chk = 1'b0; e_rd = '0;
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            e_rv0 = (rdq[0].port == 0);
            e_rv1 = (rdq[0].port == 1);
            e_chk = rdq[0].chk_data;
            e_rd  = rdq[0].data;
            void'(rdq.pop_front());
         end
         chk("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
         chk("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
         if (e_chk) chk("rdata", rdata, e_rd);

         // Arbitration for this cycle
         w = -1;
         if (p0_req && p1_req) begin
            if (m_owner >= 0) w = (m_run == LOCK_MAX) ? 1 - m_owner : m_owner;
            else              w = 1 - m_last;
         end else if (p0_req) w = 0;
         else if (p1_req)     w = 1;
         chk("p0_gnt", 32'(p0_gnt), 32'(w == 0));
         chk("p1_gnt", 32'(p1_gnt), 32'(w == 1));

         if (w >= 0) begin
            s_lock = (w == 1) ? p1_lock  : p0_lock;
            s_we   = (w == 1) ? p1_we    : p0_we;
            s_addr = (w == 1) ? p1_addr  : p0_addr;
            s_be   = (w == 1) ? p1_be    : p0_be;
            s_wd   = (w == 1) ? p1_wdata : p0_wdata;
            if (s_lock) begin
               m_run   = (m_owner == w) ? ((m_run < LOCK_MAX) ? m_run + 1 : LOCK_MAX) : 1;
               m_owner = w;
            end else begin
               m_owner = -1; m_run = 0;
            end
            m_last  = w;
            e_addr  = s_addr[12:0];
            e_wdata = s_wd;
            e_wen   = ~s_we;
            e_csn0  = s_addr[13] ? 4'hF : ~s_be;
            e_csn1  = s_addr[13] ? ~s_be : 4'hF;
            if (s_we) begin
               for (int l = 0; l < 4; l++)
                  if (s_be[l]) mmem[s_addr[13]][s_addr[5:0]][8*l +: 8] = s_wd[8*l +: 8];
            end else begin
               rdq.push_back('{due: cyc + 3, port: w, chk_data: (s_be == 4'hF),
                               data: mmem[s_addr[13]][s_addr[5:0]]});
            end
         end else begin
            m_owner = -1; m_run = 0;
            e_wen = 1'b1; e_csn0 = 4'hF; e_csn1 = 4'hF;
         end
      end
      cyc++;
   end

   // ---------------- Stimulus ----------------
   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle();
      p0_req = 1'b0; p0_lock = 1'b0; p0_we = 1'b0; p0_be = 4'h0;
      p1_req = 1'b0; p1_lock = 1'b0; p1_we = 1'b0; p1_be = 4'h0;
   endtask

   task automatic drv0(input logic lk, input logic we, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
      p0_req = 1'b1; p0_lock = lk; p0_we = we; p0_addr = a; p0_be = be; p0_wdata = wd;
   endtask

   task automatic drv1(input logic lk, input logic we, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
      p1_req = 1'b1; p1_lock = lk; p1_we = we; p1_addr = a; p1_be = be; p1_wdata = wd;
   endtask

   task automatic do_reset();
      tick();
      idle();
      hrst_n = 1'b0;
      tick();
      tick();
      hrst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      hrst_n = 1'b0;
      tick(); tick();
      #1 chk("reset_wen", 32'(wen), 32'd1);
      chk("reset_csn", 32'({bank1_csn, bank0_csn}), 32'hFF);
      hrst_n = 1'b1;

      // Preload bank0 word 5 so sram_d_3..0 = 44,33,22,11 on the read below.
      tick(); drv0(1'b0, 1'b1, 14'h0005, 4'hF, 32'h44332211);
      tick(); idle();

      // Single read
      tick(); drv0(1'b0, 1'b0, 14'h0005, 4'hF, 32'h0);
      #1 chk("rd_p0_gnt", 32'(p0_gnt), 32'd1);
      tick(); idle();
      #1 chk("rd_bank0_csn", 32'(bank0_csn), 32'h0);
      chk("rd_sram_addr", 32'(sram_addr), 32'h5);
      chk("rd_wen", 32'(wen), 32'd1);
      tick();
      #1 chk("rd_rvalid_early", 32'(p0_rvalid), 32'd0);
      tick();
      #1 chk("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
      chk("rd_rdata", rdata, 32'h44332211);
      tick();
      #1 chk("rd_rvalid_one_cycle", 32'(p0_rvalid), 32'd0);

      // Byte write on bank1
      tick(); drv1(1'b0, 1'b1, 14'h2010, 4'b0100, 32'hA5A5A5A5);
      #1 chk("wr_p1_gnt", 32'(p1_gnt), 32'd1);
      tick(); idle();
      #1 chk("wr_bank1_csn", 32'(bank1_csn), 32'hB);
      chk("wr_bank0_csn", 32'(bank0_csn), 32'hF);
      chk("wr_wen", 32'(wen), 32'd0);
      chk("wr_sram_addr", 32'(sram_addr), 32'h10);
      chk("wr_sram_wdata", sram_wdata, 32'hA5A5A5A5);
      repeat (4) tick();

      // Round-robin, no lock
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         drv0(1'b0, 1'b0, 14'h0001, 4'hF, 32'h0);
         drv1(1'b0, 1'b0, 14'h2002, 4'hF, 32'h0);
         #1 chk("rr_p0_gnt", 32'(p0_gnt), 32'(i % 2 == 0));
         chk("rr_p1_gnt", 32'(p1_gnt), 32'(i % 2 == 1));
      end
      tick(); idle();
      repeat (4) tick();

      // Lock limit: p0 locked burst while p1 keeps requesting
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         drv0(1'b1, 1'b0, 14'(i), 4'hF, 32'h0);
         drv1(1'b0, 1'b0, 14'h2003, 4'hF, 32'h0);
         #1 chk("lock_p0_gnt", 32'(p0_gnt), 32'(i < 4));
         chk("lock_p1_gnt", 32'(p1_gnt), 32'(i == 4));
      end
      tick(); idle();
      repeat (4) tick();

      // Mixed pipeline: p0 read / p1 write alternating each cycle
      for (int i = 0; i < 8; i++) begin
         tick(); idle();
         if (i % 2 == 0) drv0(1'b0, 1'b0, {8'h00, 6'(i)}, 4'hF, 32'h0);
         else            drv1(1'b0, 1'b1, {8'h00, 6'(i - 1)}, 4'hF, $urandom);
         #1;
         if (i > 0) chk("mix_wen", 32'(wen), 32'((i - 1) % 2 == 0));
      end
      tick(); idle();
      repeat (5) tick();

      // Reset in the middle of a read
      tick(); drv0(1'b0, 1'b0, 14'h0005, 4'hF, 32'h0);
      tick(); idle();
      #1 hrst_n = 1'b0;
      #1 chk("mid_rst_bank0_csn", 32'(bank0_csn), 32'hF);
      chk("mid_rst_bank1_csn", 32'(bank1_csn), 32'hF);
      tick(); tick();
      hrst_n = 1'b1;
      drv0(1'b0, 1'b0, 14'h0007, 4'hF, 32'h0);
      drv1(1'b0, 1'b0, 14'h2007, 4'hF, 32'h0);
      #1 chk("post_rst_p0_gnt", 32'(p0_gnt), 32'd1);
      chk("post_rst_p1_gnt", 32'(p1_gnt), 32'd0);
      tick(); idle();
      #1 chk("post_rst_no_rvalid", 32'(p0_rvalid), 32'd0);
      repeat (6) tick();

      // Randomized traffic with one reset partway through
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         tick(); idle();
         for (int p = 0; p < 2; p++) begin
            logic        lk, we;
            logic [13:0] a;
            logic [3:0]  be;
            if ($urandom_range(0, 9) < 6) begin
               lk = ($urandom_range(0, 9) < 4);
               we = $urandom_range(0, 1) == 1;
               a  = {1'($urandom_range(0, 1)), 7'h00, 6'($urandom_range(0, 15))};
               if (we)                           be = 4'($urandom_range(0, 15));
               else if ($urandom_range(0, 9) == 0) be = 4'h0;
               else                              be = 4'hF;
               if (p == 0) drv0(lk, we, a, be, $urandom);
               else        drv1(lk, we, a, be, $urandom);
            end
         end
      end
      tick(); idle();
      repeat (6) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
